// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encodings, size codes and defaults for mem_ctrl
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] IO_HI_DEF = 2'b11;
  localparam int ADDR_W_DEF = 32;
  function automatic logic [2:0] nbytes(input logic [1:0] s);
    return s == SZ_B ? 3'd1 : s == SZ_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_byte_pack.sv
// mem_byte_pack: write byte-lane select and little-endian read assembly
module mem_byte_pack (
  input  logic [31:0] word,
  input  logic [7:0]  din,
  input  logic [31:0] wdata,
  input  logic [1:0]  idx,
  output logic [31:0] word_nx,
  output logic [7:0]  dout
);
  always_comb begin
    word_nx = word;
    word_nx[{idx, 3'b000} +: 8] = din;
  end
  assign dout = wdata[{idx, 3'b000} +: 8];
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store ports onto a byte-wide single-port RAM
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W = ADDR_W_DEF,
  parameter logic [1:0] IO_HI  = IO_HI_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic              clear
);
  state_t state, state_n;
  logic [2:0] cnt, nb;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] size_q, idx;
  logic [31:0] wdata_q, word_q, word_nx;
  logic last_ls, ifr, idle_ok, g_ls, g_if, reading, flush, rd_step, rd_last, wr_fire, wr_last, back;
  assign nb = nbytes(size_q);
  assign ifr = if_req && !clear;
  assign idle_ok = state == IDLE && rdy_in && !if_done && !ls_done;
  assign g_ls = idle_ok && ls_req && !(last_ls && ifr);
  assign g_if = idle_ok && ifr && !g_ls;
  assign reading = state == IF_RD || state == LS_RD;
  assign flush = state == IF_RD && rdy_in && clear;
  assign rd_step = reading && rdy_in && !flush;
  assign rd_last = cnt == nb;
  assign wr_fire = state == LS_WR && rdy_in && !(addr_q[17:16] == IO_HI && io_buffer_full);
  assign wr_last = cnt == nb - 3'd1;
  // while frozen, re-present the previous read address so mem_din still holds byte cnt-1 on resume
  assign back = reading && !rdy_in && cnt != 3'd0;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (g_ls ? (ls_we ? LS_WR : LS_RD) : g_if ? IF_RD : IDLE)
            : (flush || (rd_step && rd_last) || (wr_fire && wr_last)) ? IDLE : state;
  end
  always_comb begin
    mem_a = addr_q + ADDR_W'(cnt) - ADDR_W'(back);
    mem_wr = wr_fire;
    idx = state == LS_WR ? cnt[1:0] : cnt[1:0] - 2'd1;
  end
  mem_byte_pack u_pack (
    .word(word_q), .din(mem_din), .wdata(wdata_q), .idx(idx), .word_nx(word_nx), .dout(mem_dout)
  );
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      cnt <= 3'd0;
      last_ls <= 1'b0;
      addr_q <= '0;
      size_q <= SZ_B;
      wdata_q <= '0;
      word_q <= '0;
      if_data <= '0;
      ls_rdata <= '0;
      if_done <= 1'b0;
      ls_done <= 1'b0;
    end else begin
      if_done <= rd_step && rd_last && state == IF_RD;
      ls_done <= (rd_step && rd_last && state == LS_RD) || (wr_fire && wr_last);
      if (g_ls || g_if) begin
        addr_q <= g_ls ? ls_addr : if_addr;
        size_q <= g_ls ? ls_size : SZ_W;
        wdata_q <= ls_wdata;
        word_q <= '0;
        cnt <= 3'd0;
        last_ls <= g_ls;
      end else if (rd_step) begin
        if (cnt != 3'd0) word_q <= word_nx;
        cnt <= rd_last ? 3'd0 : cnt + 3'd1;
        if (rd_last && state == IF_RD) if_data <= word_nx;
        if (rd_last && state == LS_RD) ls_rdata <= word_nx;
      end else if (wr_fire) cnt <= wr_last ? 3'd0 : cnt + 3'd1;
      else if (flush) cnt <= 3'd0;
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a registered-read RAM model
module tb_mem_ctrl;
  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, io_buffer_full = 1'b0;
  logic if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, clear = 1'b0;
  logic [1:0] ls_size = 2'd0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic [7:0] mem_din = '0, mem_dout;
  logic [31:0] mem_a, if_data, ls_rdata;
  logic mem_wr, if_done, ls_done;
  int checks = 0, errors = 0;
  logic [7:0] ram [int];

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .if_req(if_req),
    .if_addr(if_addr), .if_done(if_done), .if_data(if_data), .ls_req(ls_req), .ls_we(ls_we),
    .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done),
    .ls_rdata(ls_rdata), .clear(clear)
  );

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      'h100: return 8'h13;
      'h300: return 8'hAA;
      'h400: return 8'h11;
      'h401: return 8'h22;
      'h402: return 8'h33;
      'h403: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] peek(input int a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  always @(posedge clk_in) begin
    mem_din <= peek(int'(mem_a[17:0]));
    if (mem_wr) ram[int'(mem_a[17:0])] = mem_dout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    tick; tick;
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_dout", 32'(mem_dout), 0);
    chk("rst_if_done", 32'(if_done), 0);
    chk("rst_ls_done", 32'(ls_done), 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    rst_in = 1'b0;
    tick;
    // fetch 0x100
    if_req = 1'b1; if_addr = 32'h100;
    tick;
    chk("fetch_c0_a", mem_a, 32'h100);
    chk("fetch_c0_wr", 32'(mem_wr), 0);
    tick;
    chk("fetch_c1_a", mem_a, 32'h101);
    tick; tick; tick;
    chk("fetch_c4_done", 32'(if_done), 0);
    tick;
    chk("fetch_c5_done", 32'(if_done), 1);
    chk("fetch_data", if_data, 32'h13);
    if_req = 1'b0;
    tick;
    chk("fetch_done_pulse", 32'(if_done), 0);
    chk("fetch_data_hold", if_data, 32'h13);
    // contention: LS first, IF after turnaround, LS again after if_done
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h100;
    tick;
    chk("cont_ls_first", mem_a, 32'h300);
    tick; tick;
    chk("cont_ls_done", 32'(ls_done), 1);
    chk("cont_ls_data", ls_rdata, 32'hAA);
    tick;
    chk("cont_turn_ls", 32'(ls_done), 0);
    chk("cont_turn_if", 32'(if_done), 0);
    tick;
    chk("cont_if_second", mem_a, 32'h100);
    tick; tick; tick; tick;
    chk("cont_if_c4_ls", 32'(ls_done), 0);
    tick;
    chk("cont_if_done", 32'(if_done), 1);
    if_req = 1'b0;
    tick; tick;
    chk("cont_ls_again", mem_a, 32'h300);
    tick; tick;
    chk("cont_ls2_done", 32'(ls_done), 1);
    ls_req = 1'b0;
    tick;
    // 2-byte store 0xBEEF to 0x204
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h204; ls_wdata = 32'h0000BEEF;
    tick;
    chk("st_c0_a", mem_a, 32'h204);
    chk("st_c0_wr", 32'(mem_wr), 1);
    chk("st_c0_dout", 32'(mem_dout), 32'hEF);
    tick;
    chk("st_c1_a", mem_a, 32'h205);
    chk("st_c1_dout", 32'(mem_dout), 32'hBE);
    tick;
    chk("st_done", 32'(ls_done), 1);
    chk("st_wr_off", 32'(mem_wr), 0);
    ls_req = 1'b0;
    tick;
    chk("st_ram204", 32'(peek('h204)), 32'hEF);
    chk("st_ram205", 32'(peek('h205)), 32'hBE);
    // 1-byte load from 0x205
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h205;
    tick;
    chk("ld_c0_a", mem_a, 32'h205);
    tick;
    chk("ld_c1_done", 32'(ls_done), 0);
    tick;
    chk("ld_done", 32'(ls_done), 1);
    chk("ld_data", ls_rdata, 32'hBE);
    ls_req = 1'b0;
    tick;
    chk("ld_data_hold", ls_rdata, 32'hBE);
    // I/O store with buffer full for 3 cycles
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h5A;
    io_buffer_full = 1'b1;
    tick;
    chk("io_c0_wr", 32'(mem_wr), 0);
    tick;
    chk("io_c1_wr", 32'(mem_wr), 0);
    tick;
    chk("io_c2_wr", 32'(mem_wr), 0);
    tick;
    io_buffer_full = 1'b0;
    #1;
    chk("io_c3_wr", 32'(mem_wr), 1);
    chk("io_c3_a", mem_a, 32'h30000);
    chk("io_c3_dout", 32'(mem_dout), 32'h5A);
    tick;
    chk("io_done", 32'(ls_done), 1);
    chk("io_ram", 32'(peek('h30000)), 32'h5A);
    ls_req = 1'b0;
    tick;
    // flush a fetch at busy cycle 2
    if_req = 1'b1; if_addr = 32'h100;
    tick; tick; tick;
    clear = 1'b1; if_req = 1'b0;
    tick;
    chk("flush_no_done", 32'(if_done), 0);
    clear = 1'b0;
    // size code 3 load from 0x400 with rdy low for 2 cycles
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd3; ls_addr = 32'h400;
    tick;
    chk("flush_idle_grant", mem_a, 32'h400);
    chk("flush_if_done", 32'(if_done), 0);
    tick;
    chk("pause_c1_a", mem_a, 32'h401);
    tick;
    rdy_in = 1'b0;
    tick;
    chk("pause_wr", 32'(mem_wr), 0);
    tick;
    rdy_in = 1'b1;
    tick; tick;
    chk("pause_c6_done", 32'(ls_done), 0);
    tick;
    chk("pause_done", 32'(ls_done), 1);
    chk("pause_data", ls_rdata, 32'h44332211);
    chk("pause_if_data", if_data, 32'h13);
    ls_req = 1'b0;
    tick;
    // reset mid 4-byte write
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h500; ls_wdata = 32'hDDCCBBAA;
    tick;
    chk("rw_c0_wr", 32'(mem_wr), 1);
    tick;
    chk("rw_c1_a", mem_a, 32'h501);
    rst_in = 1'b1;
    #1;
    chk("rw_mem_a", mem_a, 0);
    chk("rw_mem_wr", 32'(mem_wr), 0);
    chk("rw_mem_dout", 32'(mem_dout), 0);
    chk("rw_ls_done", 32'(ls_done), 0);
    chk("rw_if_data", if_data, 0);
    chk("rw_ls_rdata", ls_rdata, 0);
    ls_req = 1'b0;
    tick; tick;
    rst_in = 1'b0;
    tick;
    chk("rw_no_done1", 32'(ls_done), 0);
    tick;
    chk("rw_no_done2", 32'(ls_done), 0);
    chk("rw_ram500", 32'(peek('h500)), 32'hAA);
    chk("rw_ram501", 32'(peek('h501)), 32'h00);
    // address wrap on a 2-byte load
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd1; ls_addr = 32'hFFFFFFFF;
    tick;
    chk("wrap_c0_a", mem_a, 32'hFFFFFFFF);
    tick;
    chk("wrap_c1_a", mem_a, 32'h0);
    tick; tick;
    chk("wrap_done", 32'(ls_done), 1);
    ls_req = 1'b0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
